// File: rtl/frequency_analyzer_sequencer.sv
// Drives one frequency_analyzer through repeated clear/measure windows and hands
// each window's f0/f1 totals plus an F0/F1/none decision to the host via valid/ack.
module frequency_analyzer_sequencer #(
   parameter int unsigned WINDOW_TICKS = 500000,
   parameter int unsigned CLEAR_TICKS  = 2,
   parameter int unsigned MIN_COUNT    = 1000,
   parameter bit          CONTINUOUS   = 1'b1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] f0_value,
   input  logic [31:0] f1_value,
   input  logic        result_ack,
   output logic        analyzer_enable,
   output logic        analyzer_clear,
   output logic [31:0] result_f0,
   output logic [31:0] result_f1,
   output logic [1:0]  decision,
   output logic        result_valid,
   output logic        overrun,
   output logic        busy,
   output logic [15:0] window_count
);

   localparam int unsigned CNT_MAX = (WINDOW_TICKS > CLEAR_TICKS) ? WINDOW_TICKS : CLEAR_TICKS;
   localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_TICKS - 1);
   localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      MEAS,
      SETTLE,
      CAPT
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             enable_q;
   logic             clearN_q;
   logic [31:0]      resultF0_q;
   logic [31:0]      resultF1_q;
   logic [1:0]       decision_q;
   logic             valid_q;
   logic             overrun_q;
   logic             busy_q;
   logic [15:0]      windowCount_q;

   logic [31:0]      maxVal_d;
   logic [1:0]       decision_d;

   // Classify the values currently presented by the analyzer; only latched in CAPT.
   always_comb begin
      maxVal_d   = (f0_value > f1_value) ? f0_value : f1_value;
      decision_d = 2'd0;
      if (maxVal_d >= 32'(MIN_COUNT)) begin
         if (f0_value > f1_value)
            decision_d = 2'd1;
         else if (f1_value > f0_value)
            decision_d = 2'd2;
      end
   end

   // Window sequencer; enable/clear are registered alongside the state they belong to.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         enable_q      <= 1'b0;
         clearN_q      <= 1'b0;
         resultF0_q    <= '0;
         resultF1_q    <= '0;
         decision_q    <= 2'd0;
         valid_q       <= 1'b0;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
         windowCount_q <= '0;
      end else begin
         if (valid_q && result_ack)
            valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  overrun_q <= 1'b0;
                  state_q   <= CLR;
                  cnt_q     <= CLR_LOAD;
                  busy_q    <= 1'b1;
               end
            end
            CLR, MEAS, SETTLE: begin
               if (stop) begin
                  state_q  <= IDLE;
                  enable_q <= 1'b0;
                  clearN_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else if (state_q == SETTLE) begin
                  state_q <= CAPT;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (state_q == CLR) begin
                  state_q  <= MEAS;
                  cnt_q    <= WIN_LOAD;
                  enable_q <= 1'b1;
                  clearN_q <= 1'b1;
               end else begin
                  state_q  <= SETTLE;
                  enable_q <= 1'b0;
               end
            end
            CAPT: begin
               resultF0_q    <= f0_value;
               resultF1_q    <= f1_value;
               decision_q    <= decision_d;
               valid_q       <= 1'b1;
               windowCount_q <= windowCount_q + 16'd1;
               if (valid_q && !result_ack)
                  overrun_q <= 1'b1;
               // A stop arriving during capture still lets the capture land.
               clearN_q <= 1'b0;
               if (CONTINUOUS && !stop) begin
                  state_q <= CLR;
                  cnt_q   <= CLR_LOAD;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               enable_q <= 1'b0;
               clearN_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign analyzer_enable = enable_q;
   assign analyzer_clear  = clearN_q;
   assign result_f0       = resultF0_q;
   assign result_f1       = resultF1_q;
   assign decision        = decision_q;
   assign result_valid    = valid_q;
   assign overrun         = overrun_q;
   assign busy            = busy_q;
   assign window_count    = windowCount_q;

endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// Bench for frequency_analyzer_sequencer: one single-shot instance and one continuous
// instance, both with 100-tick windows, checked against a queue of expected captures.
module tb_frequency_analyzer_sequencer;

   logic        clock;
   logic        clear;

   logic        start, stop, result_ack;
   logic [31:0] f0_value, f1_value;
   logic        analyzer_enable, analyzer_clear;
   logic [31:0] result_f0, result_f1;
   logic [1:0]  decision;
   logic        result_valid, overrun, busy;
   logic [15:0] window_count;

   logic        startC, stopC, ackC;
   logic [31:0] f0C, f1C;
   logic        enableC, clearOutC;
   logic [31:0] resF0C, resF1C;
   logic [1:0]  decisionC;
   logic        validC, overrunC, busyC;
   logic [15:0] wcC;

   typedef struct {
      logic [31:0] f0;
      logic [31:0] f1;
      logic [1:0]  dec;
   } vec_t;

   typedef struct {
      logic [31:0] f0;
      logic [31:0] f1;
      logic [1:0]  dec;
      logic [15:0] wc;
   } exp_t;

   exp_t        sb[$];
   exp_t        sbC[$];
   vec_t        vecs[9];
   int          total = 0;
   int          bad = 0;
   logic [15:0] expWc;

   frequency_analyzer_sequencer #(
      .WINDOW_TICKS(100), .CLEAR_TICKS(2), .MIN_COUNT(10), .CONTINUOUS(1'b0)
   ) dut (
      .clock(clock), .clear(clear), .start(start), .stop(stop),
      .f0_value(f0_value), .f1_value(f1_value), .result_ack(result_ack),
      .analyzer_enable(analyzer_enable), .analyzer_clear(analyzer_clear),
      .result_f0(result_f0), .result_f1(result_f1), .decision(decision),
      .result_valid(result_valid), .overrun(overrun), .busy(busy),
      .window_count(window_count)
   );

   frequency_analyzer_sequencer #(
      .WINDOW_TICKS(100), .CLEAR_TICKS(2), .MIN_COUNT(10), .CONTINUOUS(1'b1)
   ) dutC (
      .clock(clock), .clear(clear), .start(startC), .stop(stopC),
      .f0_value(f0C), .f1_value(f1C), .result_ack(ackC),
      .analyzer_enable(enableC), .analyzer_clear(clearOutC),
      .result_f0(resF0C), .result_f1(resF1C), .decision(decisionC),
      .result_valid(validC), .overrun(overrunC), .busy(busyC),
      .window_count(wcC)
   );

   // Free-running 10-unit clock; outputs are sampled on the falling edge.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitEdges(input int k);
      repeat (k) @(posedge clock);
      @(negedge clock);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] f0, input logic [31:0] f1, input logic [1:0] dec);
      exp_t e;
      f0_value = f0;
      f1_value = f1;
      expWc++;
      e.f0 = f0; e.f1 = f1; e.dec = dec; e.wc = expWc;
      sb.push_back(e);
      pulseStart();
   endtask

   task automatic collectResult();
      exp_t e;
      int   n = 0;
      while (!result_valid && n < 300) begin
         @(negedge clock);
         n++;
      end
      checkOutput("valid_arrives", 32'(result_valid), 32'd1);
      if (sb.size() == 0) begin
         checkOutput("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         checkOutput("result_f0", result_f0, e.f0);
         checkOutput("result_f1", result_f1, e.f1);
         checkOutput("decision", 32'(decision), 32'(e.dec));
         checkOutput("window_count", 32'(window_count), 32'(e.wc));
         checkOutput("busy_after_capt", 32'(busy), 32'd0);
         checkOutput("overrun_single", 32'(overrun), 32'd0);
      end
   endtask

   task automatic ackResult();
      result_ack = 1'b1;
      @(posedge clock);
      @(negedge clock);
      result_ack = 1'b0;
      checkOutput("valid_after_ack", 32'(result_valid), 32'd0);
   endtask

   // Cycle-exact window: start at edge N, clear low through N+1, enable N+2..N+101, valid at N+104.
   task automatic timedWindow(input logic [31:0] f0, input logic [31:0] f1, input logic [1:0] dec);
      applyStimulus(f0, f1, dec);
      checkOutput("t0_busy", 32'(busy), 32'd1);
      checkOutput("t0_clear", 32'(analyzer_clear), 32'd0);
      waitEdges(1);
      checkOutput("t1_clear", 32'(analyzer_clear), 32'd0);
      checkOutput("t1_enable", 32'(analyzer_enable), 32'd0);
      waitEdges(1);
      checkOutput("t2_enable", 32'(analyzer_enable), 32'd1);
      checkOutput("t2_clear", 32'(analyzer_clear), 32'd1);
      waitEdges(99);
      checkOutput("t101_enable", 32'(analyzer_enable), 32'd1);
      waitEdges(1);
      checkOutput("t102_enable", 32'(analyzer_enable), 32'd0);
      checkOutput("t102_clear", 32'(analyzer_clear), 32'd1);
      waitEdges(1);
      checkOutput("t103_valid", 32'(result_valid), 32'd0);
      checkOutput("t103_busy", 32'(busy), 32'd1);
      waitEdges(1);
      checkOutput("t104_valid", 32'(result_valid), 32'd1);
      collectResult();
   endtask

   task automatic waitCountC(input logic [15:0] target);
      int n = 0;
      while (wcC !== target && n < 300) begin
         @(negedge clock);
         n++;
      end
      checkOutput("cont_capture_arrives", 32'(wcC), 32'(target));
   endtask

   task automatic checkPopC();
      exp_t e;
      if (sbC.size() == 0) begin
         checkOutput("scoreboardC_nonempty", 32'(sbC.size()), 32'd1);
      end else begin
         e = sbC.pop_front();
         checkOutput("cont_f0", resF0C, e.f0);
         checkOutput("cont_f1", resF1C, e.f1);
         checkOutput("cont_decision", 32'(decisionC), 32'(e.dec));
         checkOutput("cont_wc", 32'(wcC), 32'(e.wc));
         checkOutput("cont_valid", 32'(validC), 32'd1);
      end
   endtask

   task automatic pushC(input logic [31:0] f0, input logic [31:0] f1, input logic [1:0] dec, input logic [15:0] wc);
      exp_t e;
      f0C = f0;
      f1C = f1;
      e.f0 = f0; e.f1 = f1; e.dec = dec; e.wc = wc;
      sbC.push_back(e);
   endtask

   initial begin
      bit stable;

      vecs[0] = '{32'd5,          32'd9,  2'd0};
      vecs[1] = '{32'd40,         32'd40, 2'd0};
      vecs[2] = '{32'd9,          32'd10, 2'd2};
      vecs[3] = '{32'hFFFF_FFFF,  32'd0,  2'd1};
      vecs[4] = '{32'd10,         32'd3,  2'd1};
      vecs[5] = '{32'd0,          32'd10, 2'd2};
      vecs[6] = '{32'd9,          32'd9,  2'd0};
      vecs[7] = '{32'd9,          32'd0,  2'd0};
      vecs[8] = '{32'd1000,       32'd999, 2'd1};

      clear = 1'b0;
      start = 1'b0; stop = 1'b0; result_ack = 1'b0;
      f0_value = '0; f1_value = '0;
      startC = 1'b0; stopC = 1'b0; ackC = 1'b0;
      f0C = '0; f1C = '0;
      expWc = '0;

      repeat (3) @(negedge clock);
      checkOutput("rst_enable", 32'(analyzer_enable), 32'd0);
      checkOutput("rst_clear", 32'(analyzer_clear), 32'd0);
      checkOutput("rst_valid", 32'(result_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_wc", 32'(window_count), 32'd0);
      checkOutput("rst_decision", 32'(decision), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      clear = 1'b1;
      waitEdges(2);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      timedWindow(32'd60, 32'd20, 2'd1);
      ackResult();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].f0, vecs[i].f1, vecs[i].dec);
         collectResult();
         ackResult();
      end

      applyStimulus(32'd123, 32'd45, 2'd1);
      collectResult();
      stable = 1'b1;
      repeat (50) begin
         @(negedge clock);
         if (result_valid !== 1'b1 || result_f0 !== 32'd123 || result_f1 !== 32'd45 || decision !== 2'd1)
            stable = 1'b0;
      end
      checkOutput("hold_stable", 32'(stable), 32'd1);
      ackResult();
      result_ack = 1'b1;
      @(posedge clock);
      @(negedge clock);
      result_ack = 1'b0;
      checkOutput("idle_ack_valid", 32'(result_valid), 32'd0);
      checkOutput("idle_ack_f0", result_f0, 32'd123);
      checkOutput("idle_ack_wc", 32'(window_count), 32'(expWc));

      f0_value = 32'd500; f1_value = 32'd1;
      pulseStart();
      waitEdges(2);
      waitEdges(49);
      checkOutput("abort_pre_enable", 32'(analyzer_enable), 32'd1);
      stop = 1'b1;
      @(posedge clock);
      @(negedge clock);
      stop = 1'b0;
      checkOutput("abort_enable", 32'(analyzer_enable), 32'd0);
      checkOutput("abort_clear", 32'(analyzer_clear), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      waitEdges(150);
      checkOutput("abort_valid", 32'(result_valid), 32'd0);
      checkOutput("abort_wc", 32'(window_count), 32'(expWc));
      checkOutput("abort_f0", result_f0, 32'd123);

      start = 1'b1; stop = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0; stop = 1'b0;
      checkOutput("startstop_busy", 32'(busy), 32'd0);
      waitEdges(110);
      checkOutput("startstop_valid", 32'(result_valid), 32'd0);

      f0_value = 32'd77; f1_value = 32'd88;
      pulseStart();
      waitEdges(30);
      #2 clear = 1'b0;
      #1;
      checkOutput("arst_enable", 32'(analyzer_enable), 32'd0);
      checkOutput("arst_clear", 32'(analyzer_clear), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_wc", 32'(window_count), 32'd0);
      checkOutput("arst_f0", result_f0, 32'd0);
      @(negedge clock);
      clear = 1'b1;
      expWc = '0;
      waitEdges(2);
      timedWindow(32'd77, 32'd88, 2'd2);
      ackResult();

      pushC(32'd30, 32'd50, 2'd2, 16'd1);
      startC = 1'b1;
      @(posedge clock);
      @(negedge clock);
      startC = 1'b0;
      waitCountC(16'd1);
      checkPopC();
      checkOutput("cont_overrun_first", 32'(overrunC), 32'd0);
      pushC(32'd70, 32'd10, 2'd1, 16'd2);
      waitCountC(16'd2);
      checkPopC();
      checkOutput("cont_overrun_second", 32'(overrunC), 32'd1);
      pushC(32'd0, 32'd500, 2'd2, 16'd3);
      waitEdges(103);
      checkOutput("cont_wc_before_third", 32'(wcC), 32'd2);
      ackC = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ackC = 1'b0;
      checkPopC();
      checkOutput("cont_overrun_third", 32'(overrunC), 32'd1);
      stopC = 1'b1;
      @(posedge clock);
      @(negedge clock);
      stopC = 1'b0;
      checkOutput("cont_stop_busy", 32'(busyC), 32'd0);
      checkOutput("cont_stop_overrun", 32'(overrunC), 32'd1);
      checkOutput("cont_stop_valid", 32'(validC), 32'd1);
      startC = 1'b1;
      @(posedge clock);
      @(negedge clock);
      startC = 1'b0;
      checkOutput("cont_restart_overrun", 32'(overrunC), 32'd0);
      checkOutput("cont_restart_busy", 32'(busyC), 32'd1);
      stopC = 1'b1;
      @(posedge clock);
      @(negedge clock);
      stopC = 1'b0;
      checkOutput("cont_final_busy", 32'(busyC), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
